// File: rtl/snd_data_packetizer.sv
// UDT data-packet header insertion for the first-transmission stream.
// Owns the first-transmission sequence and message counters and reports each completed packet.
//
// state   | meaning
// IDLE    | waiting; accepts init_seq loads, starts a packet on pay_tvalid_i
// HDR0    | emitting header word 0: {0, seq} and {PP, O, msg}
// HDR1    | emitting header word 1: timestamp and destination socket ID
// PAYLOAD | combinational pass-through of the payload stream until tlast
module snd_data_packetizer #(
   parameter logic [1:0] MSG_BOUNDARY = 2'b11,
   parameter logic       IN_ORDER     = 1'b0
) (
   input  logic        core_clk,
   input  logic        core_rst_n,
   input  logic [63:0] pay_tdata_i,
   input  logic [7:0]  pay_tkeep_i,
   input  logic        pay_tvalid_i,
   input  logic        pay_tlast_i,
   output logic        pay_tready_o,
   output logic [63:0] pkt_tdata_o,
   output logic [7:0]  pkt_tkeep_o,
   output logic        pkt_tvalid_o,
   output logic        pkt_tlast_o,
   input  logic        pkt_tready_i,
   input  logic [30:0] init_seq_i,
   input  logic        init_seq_valid_i,
   output logic        init_seq_ready_o,
   input  logic [31:0] timestamp_i,
   input  logic [31:0] dst_socket_id_i,
   output logic [30:0] sent_seq_o,
   output logic [15:0] sent_bytes_o,
   output logic        sent_valid_o
);

   typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAYLOAD} state_t;

   state_t      state_q, state_d;
   logic [30:0] seq_q, seq_d;
   logic [28:0] msg_q, msg_d;
   logic [31:0] ts_q, ts_d;
   logic [31:0] sock_q, sock_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic [30:0] sent_seq_q, sent_seq_d;
   logic [15:0] sent_bytes_q, sent_bytes_d;
   logic        sent_valid_q, sent_valid_d;

   logic [16:0] cnt_sum_w;
   logic [15:0] cnt_sat;
   logic        pay_hs;

   // Header words are big-endian on the wire; byte 0 sits in bits [7:0].
   function automatic logic [31:0] bswap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   function automatic logic [3:0] popcount8(input logic [7:0] k);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, k[i]};
      end
      return n;
   endfunction

   assign pay_hs    = (state_q == PAYLOAD) && pay_tvalid_i && pkt_tready_i;
   assign cnt_sum_w = {1'b0, byte_cnt_q} + {13'd0, popcount8(pay_tkeep_i)};
   assign cnt_sat   = cnt_sum_w[16] ? 16'hFFFF : cnt_sum_w[15:0];

   always_comb begin
      pkt_tdata_o      = 64'd0;
      pkt_tkeep_o      = 8'd0;
      pkt_tvalid_o     = 1'b0;
      pkt_tlast_o      = 1'b0;
      pay_tready_o     = 1'b0;
      init_seq_ready_o = 1'b0;
      case (state_q)
         IDLE: begin
            init_seq_ready_o = 1'b1;
         end
         HDR0: begin
            pkt_tdata_o  = {bswap32({MSG_BOUNDARY, IN_ORDER, msg_q}), bswap32({1'b0, seq_q})};
            pkt_tkeep_o  = 8'hFF;
            pkt_tvalid_o = 1'b1;
         end
         HDR1: begin
            pkt_tdata_o  = {bswap32(sock_q), bswap32(ts_q)};
            pkt_tkeep_o  = 8'hFF;
            pkt_tvalid_o = 1'b1;
         end
         PAYLOAD: begin
            pkt_tdata_o  = pay_tdata_i;
            pkt_tkeep_o  = pay_tkeep_i;
            pkt_tvalid_o = pay_tvalid_i;
            pkt_tlast_o  = pay_tlast_i;
            pay_tready_o = pkt_tready_i;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      seq_d        = seq_q;
      msg_d        = msg_q;
      ts_d         = ts_q;
      sock_d       = sock_q;
      byte_cnt_d   = byte_cnt_q;
      sent_seq_d   = sent_seq_q;
      sent_bytes_d = sent_bytes_q;
      sent_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (init_seq_valid_i) begin
               seq_d = init_seq_i;
               msg_d = 29'd0;
            end else if (pay_tvalid_i) begin
               ts_d    = timestamp_i;
               sock_d  = dst_socket_id_i;
               state_d = HDR0;
            end
         end
         HDR0: begin
            if (pkt_tready_i) state_d = HDR1;
         end
         HDR1: begin
            if (pkt_tready_i) state_d = PAYLOAD;
         end
         PAYLOAD: begin
            if (pay_hs) begin
               byte_cnt_d = cnt_sat;
               if (pay_tlast_i) begin
                  // Report the pre-increment seq alongside the final byte count.
                  sent_valid_d = 1'b1;
                  sent_seq_d   = seq_q;
                  sent_bytes_d = cnt_sat;
                  seq_d        = seq_q + 31'd1;
                  msg_d        = msg_q + 29'd1;
                  byte_cnt_d   = 16'd0;
                  state_d      = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         state_q      <= IDLE;
         seq_q        <= 31'd0;
         msg_q        <= 29'd0;
         ts_q         <= 32'd0;
         sock_q       <= 32'd0;
         byte_cnt_q   <= 16'd0;
         sent_seq_q   <= 31'd0;
         sent_bytes_q <= 16'd0;
         sent_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         seq_q        <= seq_d;
         msg_q        <= msg_d;
         ts_q         <= ts_d;
         sock_q       <= sock_d;
         byte_cnt_q   <= byte_cnt_d;
         sent_seq_q   <= sent_seq_d;
         sent_bytes_q <= sent_bytes_d;
         sent_valid_q <= sent_valid_d;
      end
   end

   assign sent_seq_o   = sent_seq_q;
   assign sent_bytes_o = sent_bytes_q;
   assign sent_valid_o = sent_valid_q;

endmodule

// File: tb/tb_snd_data_packetizer.sv
// Scoreboard bench for snd_data_packetizer: expected beats and completions are queued
// when stimulus is issued and compared as the DUT emits them.
module tb_snd_data_packetizer;

   logic        core_clk = 1'b0;
   logic        core_rst_n;
   logic [63:0] pay_tdata_i;
   logic [7:0]  pay_tkeep_i;
   logic        pay_tvalid_i;
   logic        pay_tlast_i;
   logic        pay_tready_o;
   logic [63:0] pkt_tdata_o;
   logic [7:0]  pkt_tkeep_o;
   logic        pkt_tvalid_o;
   logic        pkt_tlast_o;
   logic        pkt_tready_i;
   logic [30:0] init_seq_i;
   logic        init_seq_valid_i;
   logic        init_seq_ready_o;
   logic [31:0] timestamp_i;
   logic [31:0] dst_socket_id_i;
   logic [30:0] sent_seq_o;
   logic [15:0] sent_bytes_o;
   logic        sent_valid_o;

   snd_data_packetizer dut (
      .core_clk         (core_clk),
      .core_rst_n       (core_rst_n),
      .pay_tdata_i      (pay_tdata_i),
      .pay_tkeep_i      (pay_tkeep_i),
      .pay_tvalid_i     (pay_tvalid_i),
      .pay_tlast_i      (pay_tlast_i),
      .pay_tready_o     (pay_tready_o),
      .pkt_tdata_o      (pkt_tdata_o),
      .pkt_tkeep_o      (pkt_tkeep_o),
      .pkt_tvalid_o     (pkt_tvalid_o),
      .pkt_tlast_o      (pkt_tlast_o),
      .pkt_tready_i     (pkt_tready_i),
      .init_seq_i       (init_seq_i),
      .init_seq_valid_i (init_seq_valid_i),
      .init_seq_ready_o (init_seq_ready_o),
      .timestamp_i      (timestamp_i),
      .dst_socket_id_i  (dst_socket_id_i),
      .sent_seq_o       (sent_seq_o),
      .sent_bytes_o     (sent_bytes_o),
      .sent_valid_o     (sent_valid_o)
   );

   always #5 core_clk = ~core_clk;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        pay;
   } beat_t;

   typedef struct {
      logic [30:0] seq;
      logic [15:0] bytes;
   } sent_t;

   beat_t exp_q[$];
   sent_t sent_exp_q[$];
   int    pulse_q[$];

   int          chk_cnt = 0;
   int          pass_cnt = 0;
   int          cyc = 0;
   bit          mon_en = 1'b0;
   bit          bp_mode = 1'b0;
   bit          log_en = 1'b0;
   logic [30:0] model_seq = 31'd0;
   logic [28:0] model_msg = 29'd0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   function automatic logic [31:0] bswap(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   initial forever begin
      @(posedge core_clk);
      cyc++;
   end

   initial begin
      pkt_tready_i = 1'b1;
      forever begin
         @(posedge core_clk);
         #1;
         pkt_tready_i = bp_mode ? ~pkt_tready_i : 1'b1;
      end
   end

   // Monitor: everything sampled mid-cycle, predicting the next rising edge.
   initial forever begin
      @(negedge core_clk);
      if (mon_en) begin
         if (pkt_tvalid_o) begin
            if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
            else begin
               chk("pkt_data", pkt_tdata_o, exp_q[0].data);
               chk("pkt_keep_last", {pkt_tkeep_o, pkt_tlast_o}, {exp_q[0].keep, exp_q[0].last});
               chk("pay_ready", pay_tready_o, exp_q[0].pay ? pkt_tready_i : 1'b0);
               if (pkt_tready_i) void'(exp_q.pop_front());
            end
         end else begin
            chk("pay_ready_idle", pay_tready_o, 0);
         end
         if (sent_valid_o) begin
            if (sent_exp_q.size() == 0) chk("sent_unexpected", 1, 0);
            else begin
               sent_t s;
               s = sent_exp_q.pop_front();
               chk("sent_seq", sent_seq_o, s.seq);
               chk("sent_bytes", sent_bytes_o, s.bytes);
               if (log_en) pulse_q.push_back(cyc);
            end
         end
      end
   end

   task automatic send_packet(input int n, input logic [7:0] last_keep, input logic [31:0] ts,
                              input logic [31:0] sock, input bit hold);
      beat_t       b;
      sent_t       s;
      logic [63:0] d[$];
      int          bytes;
      bit          hs;
      int          wait_n;
      bytes  = 0;
      b.data = {bswap({2'b11, 1'b0, model_msg}), bswap({1'b0, model_seq})};
      b.keep = 8'hFF;
      b.last = 1'b0;
      b.pay  = 1'b0;
      exp_q.push_back(b);
      b.data = {bswap(sock), bswap(ts)};
      exp_q.push_back(b);
      for (int i = 0; i < n; i++) begin
         d.push_back({$urandom, $urandom});
         b.data = d[i];
         b.keep = (i == n - 1) ? last_keep : 8'hFF;
         b.last = (i == n - 1);
         b.pay  = 1'b1;
         exp_q.push_back(b);
         bytes += $countones(b.keep);
      end
      s.seq   = model_seq;
      s.bytes = (bytes > 65535) ? 16'hFFFF : 16'(bytes);
      sent_exp_q.push_back(s);
      model_seq = model_seq + 31'd1;
      model_msg = model_msg + 29'd1;

      timestamp_i     = ts;
      dst_socket_id_i = sock;
      for (int i = 0; i < n; i++) begin
         pay_tdata_i  = d[i];
         pay_tkeep_i  = (i == n - 1) ? last_keep : 8'hFF;
         pay_tlast_i  = (i == n - 1);
         pay_tvalid_i = 1'b1;
         hs     = 1'b0;
         wait_n = 0;
         while (!hs) begin
            @(negedge core_clk);
            // Once a header is out the latched copies must no longer follow the inputs.
            if (pkt_tvalid_o) begin
               timestamp_i     = ~ts;
               dst_socket_id_i = ~sock;
            end
            hs = pay_tready_o;
            @(posedge core_clk);
            #1;
            wait_n++;
            if (!hs && wait_n > 40) begin
               chk("pay_handshake_timeout", 0, 1);
               hs = 1'b1;
            end
         end
      end
      if (!hold) begin
         pay_tvalid_i = 1'b0;
         pay_tlast_i  = 1'b0;
      end
   endtask

   task automatic load_init(input logic [30:0] v);
      bit rdy;
      int wait_n;
      init_seq_i       = v;
      init_seq_valid_i = 1'b1;
      rdy    = 1'b0;
      wait_n = 0;
      while (!rdy) begin
         @(negedge core_clk);
         rdy = init_seq_ready_o;
         wait_n++;
         if (!rdy && wait_n > 60) begin
            chk("init_timeout", 0, 1);
            rdy = 1'b1;
         end
      end
      @(posedge core_clk);
      #1;
      init_seq_valid_i = 1'b0;
   endtask

   task automatic drain(input string tag);
      int wait_n;
      wait_n = 0;
      while ((exp_q.size() != 0 || sent_exp_q.size() != 0) && wait_n < 60) begin
         @(negedge core_clk);
         wait_n++;
      end
      @(posedge core_clk);
      #1;
      chk(tag, exp_q.size() + sent_exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      core_rst_n       = 1'b0;
      pay_tdata_i      = 64'd0;
      pay_tkeep_i      = 8'd0;
      pay_tvalid_i     = 1'b0;
      pay_tlast_i      = 1'b0;
      init_seq_i       = 31'd0;
      init_seq_valid_i = 1'b0;
      timestamp_i      = 32'd0;
      dst_socket_id_i  = 32'd0;
      #12;
      chk("rst_pkt_tvalid", pkt_tvalid_o, 0);
      chk("rst_init_ready", init_seq_ready_o, 1);
      chk("rst_sent_valid", sent_valid_o, 0);
      chk("rst_pkt_tdata", pkt_tdata_o, 0);
      repeat (2) @(posedge core_clk);
      #1;
      core_rst_n = 1'b1;
      mon_en     = 1'b1;

      // Basic packet
      load_init(31'h100);
      model_seq = 31'h100;
      model_msg = 29'd0;
      send_packet(3, 8'h0F, 32'h11223344, 32'hA5A5A5A5, 1'b0);
      drain("basic_drain");

      // Sequence wrap
      load_init(31'h7FFFFFFF);
      model_seq = 31'h7FFFFFFF;
      model_msg = 29'd0;
      send_packet(1, 8'h03, 32'h01020304, 32'h0BADF00D, 1'b0);
      send_packet(1, 8'h01, 32'h05060708, 32'h0BADF00D, 1'b0);
      drain("wrap_drain");

      // Backpressure 1010...
      bp_mode = 1'b1;
      send_packet(4, 8'h7F, 32'hCAFEBABE, 32'h12345678, 1'b0);
      drain("bp_drain");
      bp_mode = 1'b0;

      // Init request while in PAYLOAD is held off until IDLE
      fork
         send_packet(3, 8'hFF, 32'h0000_0042, 32'h0000_0099, 1'b0);
         begin
            int wn;
            wn = 0;
            do begin
               @(negedge core_clk);
               wn++;
            end while (!pay_tready_o && wn < 40);
            init_seq_i       = 31'h5;
            init_seq_valid_i = 1'b1;
            chk("init_held_in_payload", init_seq_ready_o, 0);
            load_init(31'h5);
         end
      join
      model_seq = 31'h5;
      model_msg = 29'd0;
      send_packet(2, 8'h3F, 32'h00ABCDEF, 32'h00000007, 1'b0);
      drain("init_mid_drain");

      // Init and packet start in the same IDLE cycle: init wins
      model_seq = 31'h1234;
      model_msg = 29'd0;
      fork
         send_packet(1, 8'h01, 32'h77777777, 32'h88888888, 1'b0);
         load_init(31'h1234);
      join
      drain("init_prio_drain");

      // Reset during HDR1
      mon_en          = 1'b0;
      timestamp_i     = 32'hDEADBEEF;
      dst_socket_id_i = 32'h01234567;
      pay_tdata_i     = 64'h1111_2222_3333_4444;
      pay_tkeep_i     = 8'hFF;
      pay_tlast_i     = 1'b0;
      pay_tvalid_i    = 1'b1;
      repeat (2) @(posedge core_clk);
      #1;
      chk("pre_rst_hdr1", pkt_tdata_o, {bswap(32'h01234567), bswap(32'hDEADBEEF)});
      core_rst_n = 1'b0;
      #1;
      chk("midrst_tvalid", pkt_tvalid_o, 0);
      chk("midrst_tdata", pkt_tdata_o, 0);
      chk("midrst_keep_last", {pkt_tkeep_o, pkt_tlast_o}, 0);
      chk("midrst_pay_ready", pay_tready_o, 0);
      chk("midrst_init_ready", init_seq_ready_o, 1);
      pay_tvalid_i = 1'b0;
      @(posedge core_clk);
      #1;
      core_rst_n = 1'b1;
      exp_q.delete();
      sent_exp_q.delete();
      model_seq = 31'd0;
      model_msg = 29'd0;
      mon_en    = 1'b1;
      send_packet(2, 8'hFF, 32'h31415926, 32'h27182818, 1'b0);
      drain("post_rst_drain");

      // Back-to-back: four 2-beat packets, pay_tvalid_i held high
      pulse_q.delete();
      log_en = 1'b1;
      for (int p = 0; p < 4; p++) begin
         send_packet(2, 8'h0F, 32'h1000 + p, 32'h2000 + p, p != 3);
      end
      drain("b2b_drain");
      log_en = 1'b0;
      chk("b2b_pulse_count", pulse_q.size(), 4);
      for (int p = 1; p < pulse_q.size(); p++) begin
         chk("b2b_period", pulse_q[p] - pulse_q[p - 1], 5);
      end

      // Byte count saturation: 8193 full beats exceed 16 bits
      send_packet(8193, 8'hFF, 32'h5A5A5A5A, 32'hC3C3C3C3, 1'b0);
      drain("sat_drain");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
